// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with frame-aligned LOAD/LOAD_ACK
// shadow update and optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int unsigned SHOW_CYC = 50000,
  parameter int unsigned GAP_CYC  = 500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP_IN,
  input  logic        LZB,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [3:0]  AN,
  output logic        LOAD_ACK,
  output logic        FRAME
);

  localparam int unsigned MAX_CYC = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYC - 1);

  typedef enum logic [1:0] {S_OFF, S_GAP, S_SHOW} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [3:0]      sdp_q, sdp_d;
  logic            pend_q, pend_d;
  logic [15:0]     pdata_q, pdata_d;
  logic [3:0]      pdp_q, pdp_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      an_q, an_d;
  logic            ack_q, ack_d;
  logic            frame_q, frame_d;
  logic [3:0]      nib;
  logic            blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_OFF;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= 16'h0000;
      sdp_q    <= 4'h0;
      pend_q   <= 1'b0;
      pdata_q  <= 16'h0000;
      pdp_q    <= 4'h0;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      an_q     <= 4'h0;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      pend_q   <= pend_d;
      pdata_q  <= pdata_d;
      pdp_q    <= pdp_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      ack_q    <= ack_d;
      frame_q  <= frame_d;
    end
  end

  // Digit i is blanked when it and every more-significant nibble are zero.
  always_comb begin
    nib = shadow_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd3:    blank = LZB && (shadow_q[15:12] == 4'h0);
      2'd2:    blank = LZB && (shadow_q[15:8] == 8'h00);
      2'd1:    blank = LZB && (shadow_q[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    pend_d   = pend_q;
    pdata_d  = pdata_q;
    pdp_d    = pdp_q;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    an_d     = 4'h0;
    ack_d    = 1'b0;
    frame_d  = 1'b0;

    // A LOAD this cycle is visible to an application in the same cycle.
    if (LOAD) begin
      pend_d  = 1'b1;
      pdata_d = DATA;
      pdp_d   = DP_IN;
    end

    case (state_q)
      S_OFF: begin
        if (pend_d) begin
          shadow_d = pdata_d;
          sdp_d    = pdp_d;
          pend_d   = 1'b0;
          ack_d    = 1'b1;
        end
        if (EN) begin
          state_d = S_GAP;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (!EN) begin
          state_d = S_OFF;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (!EN) begin
          state_d = S_OFF;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else begin
          if (!blank) begin
            an_d  = 4'b0001 << idx_q;
            seg_d = hex7(nib);
            dp_d  = ~sdp_q[idx_q];
          end
          if (cnt_q == SHOW_LAST) begin
            state_d = S_GAP;
            cnt_d   = '0;
            if (idx_q == 2'd3) begin
              idx_d   = 2'd0;
              frame_d = 1'b1;
              if (pend_d) begin
                shadow_d = pdata_d;
                sdp_d    = pdp_d;
                pend_d   = 1'b0;
                ack_d    = 1'b1;
              end
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  assign SEG      = seg_q;
  assign DP       = dp_q;
  assign AN       = an_q;
  assign LOAD_ACK = ack_q;
  assign FRAME    = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position reference model predicts
// every registered output cycle; a monitor pops and compares each cycle.
module tb_seg_scan_ctrl;
  localparam int unsigned SHOW = 4;
  localparam int unsigned GAP  = 1;
  localparam int unsigned SLOT = SHOW + GAP;
  localparam int unsigned FLEN = 4 * SLOT;

  logic        CLK = 1'b0;
  logic        RST, EN, LOAD, LZB;
  logic [15:0] DATA;
  logic [3:0]  DP_IN;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  AN;
  logic        LOAD_ACK, FRAME;

  seg_scan_ctrl #(.SHOW_CYC(SHOW), .GAP_CYC(GAP)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .DATA(DATA), .DP_IN(DP_IN),
    .LZB(LZB), .SEG(SEG), .DP(DP), .AN(AN), .LOAD_ACK(LOAD_ACK), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
    logic       frame;
  } out_t;

  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference state: scanning flag plus linear position within the frame.
  bit          m_on;
  int          m_pos;
  logic [15:0] m_sh, m_pdata;
  logic [3:0]  m_sdp, m_pdp;
  bit          m_pend;

  task automatic model_reset();
    m_on = 0; m_pos = 0; m_sh = '0; m_sdp = '0;
    m_pend = 0; m_pdata = '0; m_pdp = '0;
  endtask

  task automatic step();
    out_t e;
    int   d, w;
    logic [15:0] upper;
    e = '{an: 4'h0, seg: 7'h7F, dp: 1'b1, ack: 1'b0, frame: 1'b0};
    if (RST) begin
      model_reset();
    end else begin
      if (m_on && EN) begin
        d = m_pos / SLOT;
        w = m_pos % SLOT;
        upper = m_sh >> (4 * d);
        if (w >= GAP && !(LZB && d > 0 && upper == 16'h0)) begin
          e.an  = 4'(1 << d);
          e.seg = dec_tab[(m_sh >> (4 * d)) & 16'hF];
          e.dp  = ~m_sdp[d];
        end
      end
      if (LOAD) begin
        m_pend = 1; m_pdata = DATA; m_pdp = DP_IN;
      end
      if (!m_on) begin
        if (m_pend) begin
          m_sh = m_pdata; m_sdp = m_pdp; m_pend = 0; e.ack = 1;
        end
        if (EN) begin
          m_on = 1; m_pos = 0;
        end
      end else if (!EN) begin
        m_on = 0;
      end else begin
        if (m_pos == FLEN - 1) begin
          e.frame = 1;
          if (m_pend) begin
            m_sh = m_pdata; m_sdp = m_pdp; m_pend = 0; e.ack = 1;
          end
        end
        m_pos = (m_pos + 1) % FLEN;
      end
    end
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] dp);
    LOAD = 1; DATA = v; DP_IN = dp;
    step();
    LOAD = 0;
  endtask

  // Advance until the model reaches the given frame position (bounded).
  task automatic run_until(input int pos);
    int n = 0;
    while (!(m_on && m_pos == pos) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      bad++; total++;
      $display("FAIL run_until pos=%0d not reached got timeout required reach", pos);
    end
  endtask

  // Monitor: compare every registered output cycle against the scoreboard.
  initial begin
    out_t e, g;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{an: AN, seg: SEG, dp: DP, ack: LOAD_ACK, frame: FRAME};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got an=%b seg=%b dp=%b ack=%b frame=%b required an=%b seg=%b dp=%b ack=%b frame=%b",
                   cyc, g.an, g.seg, g.dp, g.ack, g.frame, e.an, e.seg, e.dp, e.ack, e.frame);
        end
      end
    end
  end

  initial begin
    model_reset();
    RST = 1; EN = 0; LOAD = 0; LZB = 0; DATA = '0; DP_IN = '0;
    run(2);
    RST = 0;
    run(2);
    // Plain scan of zeros.
    EN = 1;
    run(45);
    // Mid-frame load applied at frame end.
    run_until(7);
    load_once(16'h12AF, 4'b0100);
    run(45);
    // Two loads in one frame, last wins.
    run_until(3);
    load_once(16'h1111, 4'b0001);
    run(5);
    load_once(16'h2222, 4'b0000);
    run(40);
    // Load on the exact frame-end cycle.
    run_until(FLEN - 1);
    load_once(16'h3C5E, 4'b1010);
    run(25);
    // Leading-zero blanking.
    LZB = 1;
    load_once(16'h0050, 4'b1111);
    run(45);
    LZB = 0;
    // Disable mid-show of digit 2, load while off, re-enable.
    run_until(2 * SLOT + GAP + 1);
    EN = 0;
    run(3);
    load_once(16'hABCD, 4'b0011);
    run(3);
    EN = 1;
    run(25);
    // Reset with a pending load.
    run_until(3);
    load_once(16'h9876, 4'b1111);
    run_until(2 * SLOT + GAP + 2);
    RST = 1; LOAD = 1; DATA = 16'h5555;
    step();
    RST = 0; LOAD = 0;
    run(2);
    run(25);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      RST  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) EN = ~EN;
      if ($urandom_range(0, 59) == 0) LZB = ~LZB;
      LOAD = ($urandom_range(0, 11) == 0);
      DATA = ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
      DP_IN = 4'($urandom);
      step();
    end
    RST = 0; LOAD = 0;
    run(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
